// File: rtl/me_scan_ctrl.sv
// me_scan_ctrl
//    Address and control sequencer for a MACRO_DIM x MACRO_DIM PE array.
//    The array does a full search over N_X x N_Y candidate displacements.
//    It loads the current macroblock and the first search block, then
//    follows a snake path through the candidates. Each move costs one
//    search-window row or column fetch.
//
// Ports
//    clk_i, rst_i        clock, synchronous active-high reset
//    start_i             launch a search (accepted only in IDLE)
//    hold_i              memory stall, freezes the request stage
//    cur_rd_en_o/row_o   current-MB row fetch
//    sw_rd_en_o/mode_o   search-window fetch, mode 0 = row, 1 = column
//    sw_rd_x_o/y_o       search-window fetch coordinate
//    en_cpr_o, en_spr_o  PE current/search register enables (data stage)
//    sel_o               PE search mux select (data stage)
//    cand_valid_o        PE AD outputs hold candidate (mv_x_o, mv_y_o)
//    busy_o, done_o      search active, completion pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | fetching MACRO_DIM rows of current MB and search block
// DOWN    | even column, moving to increasing y
// UP      | odd column, moving to decreasing y
// RIGHT   | column fetch stepping to the next x
// DRAIN   | all requests issued, waiting for the final candidate

module me_scan_ctrl #(
   parameter int MACRO_DIM = 16,
   parameter int N_X       = 8,
   parameter int N_Y       = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic                          hold_i,
   output logic                          cur_rd_en_o,
   output logic [$clog2(MACRO_DIM)-1:0]  cur_rd_row_o,
   output logic                          sw_rd_en_o,
   output logic                          sw_rd_mode_o,
   output logic [7:0]                    sw_rd_x_o,
   output logic [7:0]                    sw_rd_y_o,
   output logic                          en_cpr_o,
   output logic                          en_spr_o,
   output logic [1:0]                    sel_o,
   output logic                          cand_valid_o,
   output logic [7:0]                    mv_x_o,
   output logic [7:0]                    mv_y_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int              RW       = $clog2(MACRO_DIM);
   localparam logic [RW-1:0]   ROW_LAST = RW'(MACRO_DIM - 1);
   localparam logic [7:0]      X_LAST   = 8'(N_X - 1);
   localparam logic [7:0]      Y_LAST   = 8'(N_Y - 1);
   localparam logic [7:0]      MD       = 8'(MACRO_DIM);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DOWN, S_UP, S_RIGHT, S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      x_q, x_d, y_q, y_d;
   logic [RW-1:0]   row_q, row_d;

   logic            req_cur, req_sw, req_mode;
   logic [7:0]      req_x, req_y;
   logic [1:0]      req_sel;
   logic [RW-1:0]   req_row;
   logic            cmp, cmp_last;
   logic [7:0]      cmp_x, cmp_y;

   logic            en_cpr_q, en_spr_q;
   logic [1:0]      sel_q;
   logic            c1_q, last1_q, c2_q, done_q;
   logic [7:0]      mvx1_q, mvy1_q, mvx2_q, mvy2_q;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      row_d    = row_q;
      req_cur  = 1'b0;
      req_sw   = 1'b0;
      req_mode = 1'b0;
      req_x    = 8'd0;
      req_y    = 8'd0;
      req_sel  = 2'd0;
      req_row  = '0;
      cmp      = 1'b0;
      cmp_last = 1'b0;
      cmp_x    = 8'd0;
      cmp_y    = 8'd0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               x_d     = 8'd0;
               y_d     = 8'd0;
               row_d   = '0;
            end
         end
         S_LOAD: begin
            // Rows go in bottom-first so the top-entry shift leaves row r at PE row r.
            if (!hold_i) begin
               req_cur = 1'b1;
               req_sw  = 1'b1;
               req_row = ROW_LAST - row_q;
               req_y   = 8'(req_row);
               if (row_q == ROW_LAST) begin
                  cmp     = 1'b1;
                  state_d = S_DOWN;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         S_DOWN: begin
            if (!hold_i && y_q < Y_LAST) begin
               req_sw  = 1'b1;
               req_x   = x_q;
               req_y   = y_q + MD;
               req_sel = 2'd1;
               y_d     = y_q + 8'd1;
               cmp     = 1'b1;
               cmp_x   = x_q;
               cmp_y   = y_d;
               if (y_d == Y_LAST) begin
                  cmp_last = (x_q == X_LAST);
                  state_d  = cmp_last ? S_DRAIN : S_RIGHT;
               end
            end
         end
         S_UP: begin
            if (!hold_i && y_q != 8'd0) begin
               req_sw  = 1'b1;
               req_x   = x_q;
               req_y   = y_q - 8'd1;
               req_sel = 2'd0;
               y_d     = y_q - 8'd1;
               cmp     = 1'b1;
               cmp_x   = x_q;
               cmp_y   = y_d;
               if (y_d == 8'd0) begin
                  cmp_last = (x_q == X_LAST);
                  state_d  = cmp_last ? S_DRAIN : S_RIGHT;
               end
            end
         end
         S_RIGHT: begin
            // Odd columns ascend, even columns descend.
            if (!hold_i && x_q < X_LAST) begin
               req_sw   = 1'b1;
               req_mode = 1'b1;
               req_x    = x_q + MD;
               req_y    = y_q;
               req_sel  = 2'd2;
               x_d      = x_q + 8'd1;
               cmp      = 1'b1;
               cmp_x    = x_d;
               cmp_y    = y_q;
               state_d  = x_d[0] ? S_UP : S_DOWN;
            end
         end
         S_DRAIN: begin
            if (done_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         x_q      <= 8'd0;
         y_q      <= 8'd0;
         row_q    <= '0;
         en_cpr_q <= 1'b0;
         en_spr_q <= 1'b0;
         sel_q    <= 2'd0;
         c1_q     <= 1'b0;
         last1_q  <= 1'b0;
         mvx1_q   <= 8'd0;
         mvy1_q   <= 8'd0;
         c2_q     <= 1'b0;
         mvx2_q   <= 8'd0;
         mvy2_q   <= 8'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         row_q    <= row_d;
         // A stalled request becomes an enable bubble in the data cycle.
         en_cpr_q <= req_cur;
         en_spr_q <= req_sw;
         if (req_sw) sel_q <= req_sel;
         c1_q     <= cmp;
         last1_q  <= cmp_last;
         mvx1_q   <= cmp_x;
         mvy1_q   <= cmp_y;
         c2_q     <= c1_q;
         mvx2_q   <= mvx1_q;
         mvy2_q   <= mvy1_q;
         done_q   <= c1_q & last1_q;
      end
   end

   assign cur_rd_en_o  = req_cur;
   assign cur_rd_row_o = req_row;
   assign sw_rd_en_o   = req_sw;
   assign sw_rd_mode_o = req_mode;
   assign sw_rd_x_o    = req_x;
   assign sw_rd_y_o    = req_y;
   assign en_cpr_o     = en_cpr_q;
   assign en_spr_o     = en_spr_q;
   assign sel_o        = sel_q;
   assign cand_valid_o = c2_q;
   assign mv_x_o       = mvx2_q;
   assign mv_y_o       = mvy2_q;
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = done_q;

endmodule

// File: tb/tb_me_scan_ctrl.sv
module tb_me_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // default-parameter instance
   logic       rst, start, hold;
   logic       cur_rd_en, sw_rd_en, sw_rd_mode, en_cpr, en_spr, cand_valid, busy, done;
   logic [3:0] cur_rd_row;
   logic [7:0] sw_rd_x, sw_rd_y, mv_x, mv_y;
   logic [1:0] sel;

   me_scan_ctrl u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .hold_i(hold),
      .cur_rd_en_o(cur_rd_en), .cur_rd_row_o(cur_rd_row),
      .sw_rd_en_o(sw_rd_en), .sw_rd_mode_o(sw_rd_mode),
      .sw_rd_x_o(sw_rd_x), .sw_rd_y_o(sw_rd_y),
      .en_cpr_o(en_cpr), .en_spr_o(en_spr), .sel_o(sel),
      .cand_valid_o(cand_valid), .mv_x_o(mv_x), .mv_y_o(mv_y),
      .busy_o(busy), .done_o(done)
   );

   // small 3x2 instance for the snake path
   logic       s_rst, s_start, s_hold;
   logic       s_cur_rd_en, s_sw_rd_en, s_sw_rd_mode, s_en_cpr, s_en_spr, s_cand_valid, s_busy, s_done;
   logic [3:0] s_cur_rd_row;
   logic [7:0] s_sw_rd_x, s_sw_rd_y, s_mv_x, s_mv_y;
   logic [1:0] s_sel;

   me_scan_ctrl #(.MACRO_DIM(16), .N_X(3), .N_Y(2)) u_snk (
      .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .hold_i(s_hold),
      .cur_rd_en_o(s_cur_rd_en), .cur_rd_row_o(s_cur_rd_row),
      .sw_rd_en_o(s_sw_rd_en), .sw_rd_mode_o(s_sw_rd_mode),
      .sw_rd_x_o(s_sw_rd_x), .sw_rd_y_o(s_sw_rd_y),
      .en_cpr_o(s_en_cpr), .en_spr_o(s_en_spr), .sel_o(s_sel),
      .cand_valid_o(s_cand_valid), .mv_x_o(s_mv_x), .mv_y_o(s_mv_y),
      .busy_o(s_busy), .done_o(s_done)
   );

   // ---------------- memory + PE array model ----------------
   logic [7:0] cur_img [16][16];
   logic [7:0] pe_cur  [16][16];
   logic [7:0] pe_sw   [16][16];
   logic [7:0] m_cur   [16];
   logic [7:0] m_sw    [16];

   function automatic logic [7:0] sw_pix(input int x, input int y);
      return 8'((x * 3 + y * 5) & 255);
   endfunction

   always @(posedge clk) begin
      if (en_cpr) begin
         for (int c = 0; c < 16; c++) begin
            pe_cur[0][c] <= m_cur[c];
            for (int r = 1; r < 16; r++) pe_cur[r][c] <= pe_cur[r-1][c];
         end
      end
      if (en_spr) begin
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
               case (sel)
                  2'd0: pe_sw[r][c] <= (r == 0) ? m_sw[c] : pe_sw[r-1][c];
                  2'd1: pe_sw[r][c] <= (r == 15) ? m_sw[c] : pe_sw[r+1][c];
                  2'd2: pe_sw[r][c] <= (c == 15) ? m_sw[r] : pe_sw[r][c+1];
                  default: pe_sw[r][c] <= 8'd0;
               endcase
      end
      for (int i = 0; i < 16; i++) begin
         m_cur[i] <= cur_img[cur_rd_row][i];
         m_sw[i]  <= sw_rd_mode ? sw_pix(int'(sw_rd_x), int'(sw_rd_y) + i)
                                : sw_pix(int'(sw_rd_x) + i, int'(sw_rd_y));
      end
   end

   function automatic int ad_errs();
      int n = 0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            int obs, gold;
            obs  = int'(pe_cur[r][c]) - int'(pe_sw[r][c]);
            obs  = (obs < 0) ? -obs : obs;
            gold = int'(cur_img[r][c]) - int'(sw_pix(int'(mv_x) + c, int'(mv_y) + r));
            gold = (gold < 0) ? -gold : gold;
            if (obs != gold) n++;
         end
      return n;
   endfunction

   // ---------------- stimulus / record / reference ----------------
   bit hold_at [400], start_at [400], rst_at [400];
   bit req_at [400], curreq_at [400], enspr_at [400], busy_at [400], zero_at [400];
   bit exp_req_at [400];
   int         cand_cyc [$];
   logic [7:0] cand_x [$], cand_y [$];
   int         done_cyc [$];
   int         exp_cyc [$];
   int         exp_x [$], exp_y [$];
   int         ad_bad;

   function automatic bit outs_zero();
      return !(cur_rd_en | sw_rd_en | sw_rd_mode | en_cpr | en_spr | cand_valid | busy | done)
             && cur_rd_row == 4'd0 && sw_rd_x == 8'd0 && sw_rd_y == 8'd0
             && sel == 2'd0 && mv_x == 8'd0 && mv_y == 8'd0;
   endfunction

   task automatic clear_stim();
      for (int c = 0; c < 400; c++) begin
         hold_at[c] = 0; start_at[c] = 0; rst_at[c] = 0;
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      clear_stim();
   endtask

   task automatic run(input int n);
      cand_cyc.delete(); cand_x.delete(); cand_y.delete(); done_cyc.delete();
      ad_bad = 0;
      for (int c = 0; c < n; c++) begin
         rst = rst_at[c]; start = start_at[c]; hold = hold_at[c];
         #1;
         req_at[c]    = sw_rd_en;
         curreq_at[c] = cur_rd_en;
         enspr_at[c]  = en_spr;
         busy_at[c]   = busy;
         zero_at[c]   = outs_zero();
         if (cand_valid) begin
            cand_cyc.push_back(c); cand_x.push_back(mv_x); cand_y.push_back(mv_y);
            ad_bad += ad_errs();
         end
         if (done) done_cyc.push_back(c);
         @(posedge clk); #1;
      end
      rst = 1'b0; start = 1'b0; hold = 1'b0;
   endtask

   // Search launched at cycle s0: every unstalled cycle after it is one
   // request; the 16th request and each later one complete a candidate
   // which is presented two cycles later, in snake order.
   task automatic ref_model(input int s0);
      int cnt = 0;
      int c = s0 + 1;
      exp_cyc.delete(); exp_x.delete(); exp_y.delete();
      for (int i = 0; i < 400; i++) exp_req_at[i] = 0;
      while (cnt < 16 + 63 && c < 396) begin
         if (!hold_at[c]) begin
            exp_req_at[c] = 1;
            cnt++;
            if (cnt >= 16) exp_cyc.push_back(c + 2);
         end
         c++;
      end
      for (int x = 0; x < 8; x++)
         for (int k = 0; k < 8; k++) begin
            exp_x.push_back(x);
            exp_y.push_back((x % 2 == 0) ? k : 7 - k);
         end
   endtask

   function automatic int cand_mismatch();
      int n = (cand_cyc.size() > exp_cyc.size()) ? cand_cyc.size() - exp_cyc.size()
                                                 : exp_cyc.size() - cand_cyc.size();
      for (int i = 0; i < cand_cyc.size() && i < exp_cyc.size(); i++)
         if (cand_cyc[i] != exp_cyc[i] || int'(cand_x[i]) != exp_x[i] || int'(cand_y[i]) != exp_y[i])
            n++;
      return n;
   endfunction

   function automatic int req_mismatch(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) begin
         if (req_at[c] != exp_req_at[c]) n++;
         if (c > 0 && enspr_at[c] != exp_req_at[c-1]) n++;
      end
      return n;
   endfunction

   task automatic drop_before(input int c0);
      while (cand_cyc.size() > 0 && cand_cyc[0] < c0) begin
         void'(cand_cyc.pop_front()); void'(cand_x.pop_front()); void'(cand_y.pop_front());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b1; hold = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (outs_zero() !== 1'b1) begin
         errors++; $display("FAIL reset_outputs: got nonzero outputs busy=%0b sel=%0d expected all 0", busy, sel);
      end
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || cur_rd_en !== 1'b0) begin
         errors++; $display("FAIL start_with_rst: got busy=%0b cur_rd_en=%0b expected 0 0", busy, cur_rd_en);
      end
   endtask

   task automatic test_basic();
      int first_req = -1, last_req = -1, first_busy = -1, last_busy = -1;
      reset_dut();
      start_at[0] = 1;
      run(100);
      ref_model(0);
      for (int c = 0; c < 100; c++) begin
         if (curreq_at[c]) begin if (first_req < 0) first_req = c; last_req = c; end
         if (busy_at[c])   begin if (first_busy < 0) first_busy = c; last_busy = c; end
      end
      checks++;
      if (first_req !== 1 || last_req !== 16) begin
         errors++; $display("FAIL load_window: got %0d..%0d expected 1..16", first_req, last_req);
      end
      checks++;
      if (cand_cyc.size() !== 64) begin
         errors++; $display("FAIL cand_count: got %0d expected 64", cand_cyc.size());
      end else begin
         checks++;
         if (cand_cyc[0] !== 18 || cand_x[0] !== 8'd0 || cand_y[0] !== 8'd0) begin
            errors++; $display("FAIL first_cand: got cyc %0d mv (%0d,%0d) expected cyc 18 mv (0,0)",
                               cand_cyc[0], cand_x[0], cand_y[0]);
         end
         checks++;
         if (cand_cyc[63] !== 81 || cand_x[63] !== 8'd7 || cand_y[63] !== 8'd0) begin
            errors++; $display("FAIL last_cand: got cyc %0d mv (%0d,%0d) expected cyc 81 mv (7,0)",
                               cand_cyc[63], cand_x[63], cand_y[63]);
         end
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 81) begin
         errors++; $display("FAIL done_basic: got %0d pulses first %0d expected 1 pulse at 81",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
      end
      checks++;
      if (first_busy !== 1 || last_busy !== 81) begin
         errors++; $display("FAIL busy_window: got %0d..%0d expected 1..81", first_busy, last_busy);
      end
      checks++;
      if (cand_mismatch() !== 0) begin
         errors++; $display("FAIL snake_default: got %0d mismatches expected 0", cand_mismatch());
      end
      checks++;
      if (req_mismatch(0, 99) !== 0) begin
         errors++; $display("FAIL req_timing_basic: got %0d mismatches expected 0", req_mismatch(0, 99));
      end
      checks++;
      if (ad_bad !== 0) begin
         errors++; $display("FAIL ad_basic: got %0d bad pixels expected 0", ad_bad);
      end
   endtask

   task automatic test_hold();
      int bad = 0;
      reset_dut();
      start_at[0] = 1;
      for (int c = 21; c <= 23; c++) hold_at[c] = 1;
      run(110);
      ref_model(0);
      for (int c = 21; c <= 23; c++) if (req_at[c]) bad++;
      for (int c = 22; c <= 24; c++) if (enspr_at[c]) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL hold_pause: got %0d active slots expected 0", bad);
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 84) begin
         errors++; $display("FAIL hold_done: got %0d pulses first %0d expected 1 pulse at 84",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
      end
      checks++;
      if (cand_mismatch() !== 0) begin
         errors++; $display("FAIL hold_cands: got %0d mismatches expected 0", cand_mismatch());
      end
      checks++;
      if (ad_bad !== 0) begin
         errors++; $display("FAIL hold_ad: got %0d bad pixels expected 0", ad_bad);
      end
   endtask

   task automatic test_random_hold();
      for (int it = 0; it < 3; it++) begin
         reset_dut();
         start_at[0] = 1;
         for (int c = 1; c <= 90; c++) hold_at[c] = ($urandom_range(3, 0) == 0);
         run(200);
         ref_model(0);
         checks++;
         if (cand_mismatch() !== 0) begin
            errors++; $display("FAIL rand_cands[%0d]: got %0d mismatches expected 0", it, cand_mismatch());
         end
         checks++;
         if (req_mismatch(0, 199) !== 0) begin
            errors++; $display("FAIL rand_req[%0d]: got %0d mismatches expected 0", it, req_mismatch(0, 199));
         end
         checks++;
         if (done_cyc.size() !== 1 || done_cyc[0] !== exp_cyc[$]) begin
            errors++; $display("FAIL rand_done[%0d]: got %0d pulses first %0d expected 1 at %0d", it,
                               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_cyc[$]);
         end
         checks++;
         if (ad_bad !== 0) begin
            errors++; $display("FAIL rand_ad[%0d]: got %0d bad pixels expected 0", it, ad_bad);
         end
      end
   endtask

   task automatic test_restart_ignored();
      reset_dut();
      start_at[0] = 1;
      start_at[40] = 1;
      run(120);
      ref_model(0);
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 81) begin
         errors++; $display("FAIL restart_done: got %0d pulses first %0d expected 1 pulse at 81",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
      end
      checks++;
      if (cand_mismatch() !== 0) begin
         errors++; $display("FAIL restart_cands: got %0d mismatches expected 0", cand_mismatch());
      end
   endtask

   task automatic test_rst_mid();
      reset_dut();
      start_at[0] = 1;
      rst_at[50] = 1;
      start_at[55] = 1;
      run(160);
      ref_model(55);
      checks++;
      if (zero_at[51] !== 1'b1 || busy_at[51] !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outputs: got zero=%0b busy=%0b expected 1 0", zero_at[51], busy_at[51]);
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 136) begin
         errors++; $display("FAIL rst_mid_done: got %0d pulses first %0d expected 1 pulse at 136",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
      end
      drop_before(52);
      checks++;
      if (cand_mismatch() !== 0) begin
         errors++; $display("FAIL rst_mid_cands: got %0d mismatches expected 0", cand_mismatch());
      end
      checks++;
      if (req_mismatch(52, 159) !== 0) begin
         errors++; $display("FAIL rst_mid_req: got %0d mismatches expected 0", req_mismatch(52, 159));
      end
      checks++;
      if (ad_bad !== 0) begin
         errors++; $display("FAIL rst_mid_ad: got %0d bad pixels expected 0", ad_bad);
      end
   endtask

   task automatic test_snake_small();
      int ex_x [6], ex_y [6];
      int         got_x [$], got_y [$], col_x [$], col_y [$];
      int         dcyc = -1;
      int         nbad = 0;
      ex_x = '{0, 0, 1, 1, 2, 2};
      ex_y = '{0, 1, 1, 0, 0, 1};
      s_rst = 1'b1; s_start = 1'b0; s_hold = 1'b0;
      @(posedge clk); #1;
      s_rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         s_start = (c == 0);
         #1;
         if (s_cand_valid) begin got_x.push_back(int'(s_mv_x)); got_y.push_back(int'(s_mv_y)); end
         if (s_sw_rd_en && s_sw_rd_mode) begin col_x.push_back(int'(s_sw_rd_x)); col_y.push_back(int'(s_sw_rd_y)); end
         if (s_done && dcyc < 0) dcyc = c;
         @(posedge clk); #1;
      end
      s_start = 1'b0;
      checks++;
      if (got_x.size() !== 6) begin
         errors++; $display("FAIL snake_count: got %0d expected 6", got_x.size());
      end else begin
         for (int i = 0; i < 6; i++) if (got_x[i] != ex_x[i] || got_y[i] != ex_y[i]) nbad++;
         checks++;
         if (nbad !== 0) begin
            errors++; $display("FAIL snake_order: got %0d wrong positions expected 0", nbad);
         end
      end
      checks++;
      if (col_x.size() !== 2) begin
         errors++; $display("FAIL snake_cols: got %0d column fetches expected 2", col_x.size());
      end else begin
         checks++;
         if (col_x[0] !== 16 || col_y[0] !== 1 || col_x[1] !== 17 || col_y[1] !== 0) begin
            errors++; $display("FAIL snake_col_addr: got (%0d,%0d)(%0d,%0d) expected (16,1)(17,0)",
                               col_x[0], col_y[0], col_x[1], col_y[1]);
         end
      end
      checks++;
      if (dcyc !== 23) begin
         errors++; $display("FAIL snake_done: got %0d expected 23", dcyc);
      end
   endtask

   initial begin
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) cur_img[r][c] = 8'($urandom_range(255, 0));
      s_rst = 1'b1; s_start = 1'b0; s_hold = 1'b0;
      clear_stim();
      test_reset();
      test_basic();
      test_hold();
      test_random_hold();
      test_restart_ignored();
      test_rst_mid();
      test_snake_small();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
